// File: rtl/store_truncation_unit.sv
// rtl/store_truncation_unit.sv - narrowing store path: truncates a register value to byte/half/word and writes it byte-serially, little-endian.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned half/word requests.
module store_truncation_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [7:0]            o_mem_data,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            last_q, last_d;
  logic [1:0]            k_q, k_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_data_q, mem_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  busy_q, busy_d;
  logic                  reject;
  logic [1:0]            size_last;
  logic [1:0]            kn;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= '0;
      k_q        <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      k_q        <= k_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    reject = (i_size == 2'b11);
`ifdef STORE_ALIGN_CHECK_EN
    if ((i_size == 2'b01) && i_addr[0])
      reject = 1'b1;
    if ((i_size == 2'b10) && (i_addr[1:0] != 2'b00))
      reject = 1'b1;
`else
`endif
    case (i_size)
      2'b00:   size_last = 2'd0;
      2'b01:   size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  end

  // Output registers are loaded one cycle ahead, so byte 0 is presented in the cycle after accept.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    k_d        = k_q;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    kn         = k_q + 2'd1;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (reject) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            state_d    = WRITE;
            addr_d     = i_addr;
            data_d     = i_data;
            last_d     = size_last;
            k_d        = 2'd0;
            mem_we_d   = 1'b1;
            mem_addr_d = i_addr;
            mem_data_d = i_data[7:0];
            done_d     = (size_last == 2'd0);
          end
        end
      end
      WRITE: begin
        if (k_q == last_q) begin
          state_d = IDLE;
        end else begin
          k_d        = kn;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q + ADDR_WIDTH'(kn);
          mem_data_d = data_q[{kn, 3'b000} +: 8];
          done_d     = (kn == last_q);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign o_ready    = (state_q == IDLE) && !i_reset;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_busy     = busy_q;

endmodule

// File: doc/store_truncation_unit.md
# store_truncation_unit

Narrowing store path for the MEM stage: accepts one store request (32-bit register value, byte address, access size) and truncates the value to byte, halfword or word. It then issues the kept bytes one per cycle to the byte-wide data memory write port, in little-endian order. It is the inverse of the immediate/load extension path: it drops the upper bits instead of replicating them.

## Interface
- `ADDR_WIDTH`, default 10: byte-address width of the data memory.
- `DATA_WIDTH`, default 32: register width; fixed at 32, other values unsupported.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_reset`  in  1  reset is synchronous and active-high.
- `i_valid`  in  1  store request valid.
- `o_ready`  out  1  unit can accept a request this cycle.
- `i_addr`  in  ADDR_WIDTH  byte address of first byte.
- `i_data`  in  32  register value to store.
- `i_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `o_mem_we`  out  1  byte write strobe.
- `o_mem_addr`  out  ADDR_WIDTH  byte address of current write.
- `o_mem_data`  out  8  byte being written.
- `o_done`  out  1  one-cycle pulse on the last byte write of a request.
- `o_error`  out  1  one-cycle pulse when a request is rejected.
- `o_busy`  out  1  request in progress (not IDLE).

## Operation
States:
- **IDLE**: waiting for a request.
- **WRITE**: emitting bytes.
- **ERR**: single-cycle reject.

Acceptance:
- Handshake completes when `i_valid && o_ready`.
- `o_ready` is 1 only in IDLE and only when `i_reset` is low.
- On accept, the unit latches `i_addr`, `i_data` and count N (byte=1, half=2, word=4). A byte counter k is cleared.

Truncation:
- Byte k is `i_data[8k+7:8k]` for k < N. Bits at or above 8N are discarded, not inspected, and never written.

WRITE state, cycle k:
- `o_mem_we`=1, `o_mem_addr`=latched addr + k (modulo 2^ADDR_WIDTH, wraps silently), `o_mem_data`=byte k.
- On k = N-1: `o_done`=1 and the FSM returns to IDLE.

Rejection:
- `i_size`=11 is always rejected. The FSM goes to ERR, which asserts `o_error`=1 and `o_mem_we`=0 for one cycle, then returns to IDLE.
- No memory write ever occurs for a rejected request.

Other rules:
- `i_valid` while not ready is ignored. No queueing; the requester holds its request.
- Request inputs are sampled only at acceptance; later changes do not affect an in-flight store.

## Timing
- All outputs are registered.
- Reset values: `o_mem_we`=0, `o_mem_addr`=0, `o_mem_data`=0, `o_done`=0, `o_error`=0, `o_busy`=0. `o_ready`=0 while `i_reset`=1, and 1 in the first cycle after reset deasserts. The FSM resets to IDLE.
- Accepting request in cycle T: writes occur in cycles T+1 … T+N, `o_done` in cycle T+N, `o_ready` high again in T+N+1. Occupancy is N+1 cycles per request.
- Rejected request accepted in T: `o_error` in T+1, `o_ready` high in T+2.
- `o_busy` = !IDLE, registered alongside the state.
- Reset mid-request: at the next edge the FSM goes to IDLE, remaining bytes are abandoned, all outputs go to reset values, and no `o_done` or `o_error` is issued for that request.
- Back-to-back: a new request can be accepted in the cycle immediately after `o_done`.

## Configuration
- `STORE_ALIGN_CHECK_EN` defined: a half with `i_addr[0]`=1, or a word with `i_addr[1:0]`≠00, is rejected via ERR (same timing as the illegal size, zero writes).
- `STORE_ALIGN_CHECK_EN` undefined: misaligned requests are accepted and written byte-serially at addr, addr+1, …, with wrap-around. The size-11 rejection is unaffected.

## Test plan
- Word store, addr 0x010, data 0xA1B2C3D4, size 10 → writes (0x010,D4), (0x011,C3), (0x012,B2), (0x013,A1) in T+1..T+4; `o_done` at T+4; ready at T+5.
- Byte store, addr 0x3FF, data 0xFFFFFF7E, size 00 → single write (0x3FF,7E); no other writes; `o_done` at T+1.
- Half store at addr 0x3FF, data 0x00001234 → without macro: writes (0x3FF,34), (0x000,12) (wrap). With `STORE_ALIGN_CHECK_EN`: `o_error` at T+1, no `o_mem_we`.
- Size 11 → `o_error` pulse at T+1, zero writes, ready at T+2. Then a byte store accepted at T+2 writes at T+3.
- Word store, `i_reset` asserted during the second byte cycle → at most two writes seen, no `o_done`, all outputs 0 next cycle, and the next request behaves normally.
- `i_valid` held high with `i_data` changing every cycle during a word store → the written bytes match the value latched at acceptance only.
